// File: rtl/shift_r_seq_if.sv
// shift_r_seq_if: request/result bundle for the sequential right shifter
interface shift_r_seq_if;
  logic        start_i;
  logic [15:0] in_i;
  logic [3:0]  amt_i;
  logic        arith_i;
  logic [15:0] out_o;
  logic        busy_o;
  logic        done_o;
  modport master (output start_i, in_i, amt_i, arith_i, input out_o, busy_o, done_o);
  modport slave  (input start_i, in_i, amt_i, arith_i, output out_o, busy_o, done_o);
endinterface

// File: rtl/shift_r_seq.sv
// shift_r_seq: one-bit-per-cycle right shifter; arithmetic fill enabled by SHIFT_R_SEQ_ARITH_EN
module shift_r_seq (
  input  logic         clk,
  input  logic         rst,
  shift_r_seq_if.slave b
);
`ifdef SHIFT_R_SEQ_ARITH_EN
  localparam logic ARITH_EN = 1'b1;
`else
  localparam logic ARITH_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fill_q, fill_d;
  // next state: capture on accepted start, shift one bit per SHIFT cycle, single DONE cycle
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    unique case (state_q)
      IDLE: if (b.start_i) begin
        sr_d    = b.in_i;
        cnt_d   = b.amt_i;
        fill_d  = ARITH_EN & b.arith_i & b.in_i[15];
        state_d = b.amt_i == 4'd0 ? DONE : SHIFT;
      end
      SHIFT: begin
        sr_d    = {fill_q, sr_q[15:1]};
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? DONE : SHIFT;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end
  assign b.out_o  = sr_q;
  assign b.busy_o = state_q != IDLE;
  assign b.done_o = state_q == DONE;
endmodule

// File: tb/tb_shift_r_seq.sv
// tb_shift_r_seq: table, corner-sequence and random checks of shift_r_seq
module tb_shift_r_seq;
`ifdef SHIFT_R_SEQ_ARITH_EN
  localparam bit AE = 1'b1;
`else
  localparam bit AE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  shift_r_seq_if bus ();
  shift_r_seq dut (.clk(clk), .rst(rst), .b(bus.slave));
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [3:0]  amt;
    logic        arith;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[7];

  function automatic logic [15:0] ref_shift(logic [15:0] din, logic [3:0] amt, logic arith);
    logic signed [15:0] s;
    s = din;
    return (AE && arith) ? 16'(s >>> amt) : din >> amt;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(string name, logic [15:0] din, logic [3:0] amt, logic arith,
                        logic [15:0] exp, bit noisy);
    int lat;
    int pulses;
    bus.start_i = 1'b1;
    bus.in_i    = din;
    bus.amt_i   = amt;
    bus.arith_i = arith;
    step();
    lat = 1;
    pulses = 0;
    bus.start_i = 1'b0;
    if (noisy) begin
      bus.in_i    = 16'($urandom);
      bus.amt_i   = 4'($urandom);
      bus.arith_i = 1'($urandom);
    end
    while (!bus.done_o && lat < 20) begin
      if (!bus.busy_o) begin
        errors++;
        checks++;
        $display("FAIL %s busy: got 0 expected 1 at cycle %0d", name, lat);
      end
      if (noisy) begin
        bus.start_i = 1'($urandom);
        bus.in_i    = 16'($urandom);
      end
      step();
      lat++;
    end
    chk({name, " latency"}, lat, amt + 1);
    chk({name, " out"}, bus.out_o, exp);
    chk({name, " busy in done"}, bus.busy_o, 1'b1);
    if (noisy) bus.start_i = 1'($urandom);
    step();
    bus.start_i = 1'b0;
    chk({name, " done pulse width"}, bus.done_o, 1'b0);
    chk({name, " busy after"}, bus.busy_o, 1'b0);
    chk({name, " out held"}, bus.out_o, exp);
  endtask

  initial begin
    int pulses;
    bus.start_i = 1'b0;
    bus.in_i    = '0;
    bus.amt_i   = '0;
    bus.arith_i = 1'b0;
    tbl[0] = '{16'hB6A4, 4'd4,  1'b0, 16'h0B6A};
    tbl[1] = '{16'hB6A4, 4'd4,  1'b1, AE ? 16'hFB6A : 16'h0B6A};
    tbl[2] = '{16'h1234, 4'd0,  1'b0, 16'h1234};
    tbl[3] = '{16'h8000, 4'd15, 1'b1, AE ? 16'hFFFF : 16'h0001};
    tbl[4] = '{16'h8000, 4'd15, 1'b0, 16'h0001};
    tbl[5] = '{16'hFFFF, 4'd1,  1'b1, AE ? 16'hFFFF : 16'h7FFF};
    tbl[6] = '{16'h7FFF, 4'd3,  1'b1, 16'h0FFF};
    step();
    bus.start_i = 1'b1;
    bus.in_i    = 16'hFFFF;
    step();
    chk("reset out", bus.out_o, 16'h0000);
    chk("reset busy", bus.busy_o, 1'b0);
    chk("reset done", bus.done_o, 1'b0);
    rst = 1'b0;
    bus.start_i = 1'b0;
    step();
    chk("idle after reset busy", bus.busy_o, 1'b0);
    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].din, tbl[i].amt, tbl[i].arith, tbl[i].exp, 1'b0);
      step();
      chk($sformatf("vec%0d idle hold", i), bus.out_o, tbl[i].exp);
    end
    // start pulses during SHIFT (cycle 2) and DONE (cycle 7) are ignored
    bus.start_i = 1'b1;
    bus.in_i    = 16'h1234;
    bus.amt_i   = 4'd6;
    bus.arith_i = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      bus.start_i = 1'b0;
      pulses += int'(bus.done_o);
      if (c == 2 || c == 7) begin
        bus.start_i = 1'b1;
        bus.in_i    = 16'hA5A5 + 16'(c);
        bus.amt_i   = 4'd1;
      end
      if (c == 7) chk("busy_ignore done c7", bus.done_o, 1'b1);
      if (c == 8) begin
        chk("busy_ignore busy c8", bus.busy_o, 1'b0);
        chk("busy_ignore out", bus.out_o, 16'h0048);
      end
    end
    step();
    chk("busy_ignore pulses", pulses, 1);
    chk("busy_ignore no requeue", bus.busy_o, 1'b0);
    // reset mid-operation, with start in the reset cycle discarded
    bus.start_i = 1'b1;
    bus.in_i    = 16'hF0F0;
    bus.amt_i   = 4'd10;
    step();
    bus.start_i = 1'b0;
    step();
    step();
    rst = 1'b1;
    bus.start_i = 1'b1;
    step();
    rst = 1'b0;
    bus.start_i = 1'b0;
    chk("abort busy", bus.busy_o, 1'b0);
    chk("abort out", bus.out_o, 16'h0000);
    chk("abort done", bus.done_o, 1'b0);
    pulses = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      pulses += int'(bus.done_o) + int'(bus.busy_o);
    end
    chk("abort quiet", pulses, 0);
    run_op("after abort", 16'hC3C3, 4'd2, 1'b1, ref_shift(16'hC3C3, 4'd2, 1'b1), 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [15:0] d;
      logic [3:0]  a;
      logic        s;
      d = 16'($urandom);
      a = 4'($urandom);
      s = 1'($urandom);
      run_op($sformatf("rand%0d", i), d, a, s, ref_shift(d, a, s), 1'b1);
      repeat ($urandom_range(0, 2)) step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
